// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - parametrised register file with write bypass and busy scoreboard
//
// Two combinational read ports, one clocked write port, and a per-register
// busy bit that multi-cycle producers set at issue and writeback clears.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rd_addr1/2            read indices
//   rd_data1/2            read data (combinational, optionally bypassed)
//   rd_busy1/2            pending-write flag for the addressed register
//   wr_en/wr_addr/wr_data writeback strobe, index and data
//   issue_en/issue_addr   marks a destination busy for a multi-cycle producer
//   busy_vec              registered scoreboard, bit i = register i busy

module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rd_addr1,
    output logic [DATA_W-1:0]      rd_data1,
    output logic                   rd_busy1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data2,
    output logic                   rd_busy2,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_ok;
    logic                issue_ok;

    // Index 0 swallows writes and issues when it is the hard-wired zero.
    assign wr_ok    = wr_en    && !(ZERO_REG && (wr_addr == '0));
    assign issue_ok = issue_en && !(ZERO_REG && (issue_addr == '0));

    // Clear first, then set: an issue and a writeback to the same index in
    // one cycle leaves the register busy for the newly issued producer.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            busy_q <= busy_nxt;
        end
    end

    function automatic logic is_zero_idx(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        if (!rst_n || is_zero_idx(a)) begin
            return '0;
        end
        if (BYPASS && wr_en && (wr_addr == a)) begin
            return wr_data;
        end
        return regs[a];
    endfunction

    // A same-cycle writeback hides the busy bit it is about to clear, unless
    // a new producer is issuing to that same register in this cycle.
    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        if (!rst_n || is_zero_idx(a)) begin
            return 1'b0;
        end
        if (BYPASS && wr_en && (wr_addr == a) && !(issue_en && (issue_addr == a))) begin
            return 1'b0;
        end
        return busy_q[a];
    endfunction

    assign rd_data1 = read_data(rd_addr1);
    assign rd_data2 = read_data(rd_addr2);
    assign rd_busy1 = read_busy(rd_addr1);
    assign rd_busy2 = read_busy(rd_addr2);
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - scoreboard bench for mips_regfile_sb in three parameter builds

module tb_mips_regfile_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for builds A (BYPASS=1) and B (BYPASS=0), 32x32, zero reg.
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [31:0] wr_data;
    logic        wr_en, issue_en;

    logic [31:0] a_d1, a_d2, b_d1, b_d2, a_bv, b_bv;
    logic        a_b1, a_b2, b_b1, b_b2;

    // Build C: 64-bit x 64 regs, index 0 a normal register.
    logic [5:0]  c_rd_addr1, c_rd_addr2, c_wr_addr, c_issue_addr;
    logic [63:0] c_wr_data;
    logic        c_wr_en, c_issue_en;
    logic [63:0] c_d1, c_d2, c_bv;
    logic        c_b1, c_b2;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(a_d1), .rd_busy1(a_b1),
        .rd_addr2(rd_addr2), .rd_data2(a_d2), .rd_busy2(a_b2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(a_bv)
    );

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(b_d1), .rd_busy1(b_b1),
        .rd_addr2(rd_addr2), .rd_data2(b_d2), .rd_busy2(b_b2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(b_bv)
    );

    mips_regfile_sb #(.DATA_W(64), .ADDR_W(6), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(c_rd_addr1), .rd_data1(c_d1), .rd_busy1(c_b1),
        .rd_addr2(c_rd_addr2), .rd_data2(c_d2), .rd_busy2(c_b2),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .issue_en(c_issue_en), .issue_addr(c_issue_addr), .busy_vec(c_bv)
    );

    localparam int S_A_D1 = 0, S_A_D2 = 1, S_A_B1 = 2, S_A_BV = 3;
    localparam int S_B_D1 = 4, S_B_D2 = 5, S_B_B1 = 6, S_B_BV = 7;
    localparam int S_C_D1 = 8, S_C_D2 = 9, S_C_BV = 10, S_C_B1 = 11;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_A_D1: return {32'h0, a_d1};
            S_A_D2: return {32'h0, a_d2};
            S_A_B1: return {63'h0, a_b1};
            S_A_BV: return {32'h0, a_bv};
            S_B_D1: return {32'h0, b_d1};
            S_B_D2: return {32'h0, b_d2};
            S_B_B1: return {63'h0, b_b1};
            S_B_BV: return {32'h0, b_bv};
            S_C_D1: return c_d1;
            S_C_D2: return c_d2;
            S_C_BV: return c_bv;
            S_C_B1: return {63'h0, c_b1};
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_issue_en = 1'b0; c_issue_addr = '0;
        c_rd_addr1 = '0; c_rd_addr2 = '0;
    endtask

    // Sample combinational outputs on the falling edge, then step to just after the next rise.
    task automatic settle_and_tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        // Reset held: a pending write must not bypass onto the read port.
        rd_addr1 = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_0001;
        expect_val("rst_bypass_gated", S_A_D1, 64'h0);
        expect_val("rst_busy_vec", S_A_BV, 64'h0);
        expect_val("rst_c_busy_vec", S_C_BV, 64'h0);
        settle_and_tick();
        rst_n = 1'b1;

        // Write r5 and issue r6, then reset asynchronously mid-cycle.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        issue_en = 1'b1; issue_addr = 5'd6;
        settle_and_tick();
        rd_addr1 = 5'd5;
        expect_val("r5_written", S_A_D1, 64'hDEAD_BEEF);
        expect_val("r6_busy_pre_rst", S_A_BV, 64'h40);
        #2 drain();
        rst_n = 1'b0;
        #1;
        expect_val("r5_async_clr", S_A_D1, 64'h0);
        expect_val("busy_async_clr", S_A_BV, 64'h0);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Hard-wired zero register ignores writes and issues.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        expect_val("r0_data_same", S_A_D1, 64'h0);
        expect_val("r0_busy_same", S_A_B1, 64'h0);
        settle_and_tick();
        expect_val("r0_data_after", S_A_D1, 64'h0);
        expect_val("r0_busy_vec", S_A_BV, 64'h0);
        settle_and_tick();

        // Bypass versus stored value.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h11;
        settle_and_tick();
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h22; rd_addr2 = 5'd8;
        expect_val("bypass_on", S_A_D2, 64'h22);
        expect_val("bypass_off", S_B_D2, 64'h11);
        settle_and_tick();
        rd_addr2 = 5'd8;
        expect_val("r8_next_a", S_A_D2, 64'h22);
        expect_val("r8_next_b", S_B_D2, 64'h22);
        settle_and_tick();

        // Issue r9, observe busy, then writeback clears it.
        issue_en = 1'b1; issue_addr = 5'd9;
        settle_and_tick();
        rd_addr1 = 5'd9;
        expect_val("r9_busy_a", S_A_B1, 64'h1);
        expect_val("r9_busy_b", S_B_B1, 64'h1);
        settle_and_tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h5; rd_addr1 = 5'd9;
        expect_val("r9_wb_busy_a", S_A_B1, 64'h0);
        expect_val("r9_wb_busy_b", S_B_B1, 64'h1);
        expect_val("r9_wb_data_a", S_A_D1, 64'h5);
        expect_val("r9_wb_data_b", S_B_D1, 64'h0);
        expect_val("r9_wb_vec", S_A_BV, 64'h200);
        settle_and_tick();
        expect_val("r9_clr_vec_a", S_A_BV, 64'h0);
        expect_val("r9_clr_vec_b", S_B_BV, 64'h0);
        settle_and_tick();

        // Collision: writeback and re-issue on the same busy register.
        issue_en = 1'b1; issue_addr = 5'd10;
        settle_and_tick();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h7;
        issue_en = 1'b1; issue_addr = 5'd10; rd_addr1 = 5'd10;
        expect_val("coll_busy_same", S_A_B1, 64'h1);
        settle_and_tick();
        rd_addr1 = 5'd10;
        expect_val("coll_data", S_A_D1, 64'h7);
        expect_val("coll_vec_a", S_A_BV, 64'h400);
        expect_val("coll_vec_b", S_B_BV, 64'h400);
        settle_and_tick();

        // Writeback r10 and issue r12 in one cycle: independent updates.
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h8;
        issue_en = 1'b1; issue_addr = 5'd12;
        settle_and_tick();
        expect_val("split_vec", S_A_BV, 64'h1000);
        settle_and_tick();

        // Wide build: r31 and r63 must not alias; r0 is an ordinary register.
        c_wr_en = 1'b1; c_wr_addr = 6'd31; c_wr_data = 64'h55;
        settle_and_tick();
        c_wr_en = 1'b1; c_wr_addr = 6'd63; c_wr_data = 64'h0123_4567_89AB_CDEF;
        settle_and_tick();
        c_wr_en = 1'b1; c_wr_addr = 6'd0; c_wr_data = 64'hAB;
        c_issue_en = 1'b1; c_issue_addr = 6'd0;
        c_rd_addr1 = 6'd63; c_rd_addr2 = 6'd63;
        expect_val("c_r63_p1", S_C_D1, 64'h0123_4567_89AB_CDEF);
        expect_val("c_r63_p2", S_C_D2, 64'h0123_4567_89AB_CDEF);
        settle_and_tick();
        c_rd_addr1 = 6'd0; c_rd_addr2 = 6'd31;
        expect_val("c_r31", S_C_D2, 64'h55);
        expect_val("c_r0_data", S_C_D1, 64'hAB);
        expect_val("c_r0_busy", S_C_B1, 64'h1);
        expect_val("c_busy_vec", S_C_BV, 64'h1);
        settle_and_tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
